// File: rtl/hram_io_responder_pkg.sv
// Shared constants for the high-page responder: register addresses,
// interrupt bit positions and the timer tap selection.
package hram_io_responder_pkg;

   localparam logic [15:0] ADDR_DIV  = 16'hFF04;
   localparam logic [15:0] ADDR_TIMA = 16'hFF05;
   localparam logic [15:0] ADDR_TMA  = 16'hFF06;
   localparam logic [15:0] ADDR_TAC  = 16'hFF07;
   localparam logic [15:0] ADDR_IF   = 16'hFF0F;
   localparam logic [15:0] ADDR_IE   = 16'hFFFF;

   typedef enum logic [2:0] {
      INT_VBLANK = 3'd0,
      INT_STAT   = 3'd1,
      INT_TIMER  = 3'd2,
      INT_SERIAL = 3'd3,
      INT_JOYPAD = 3'd4
   } int_bit_e;

   typedef enum logic [1:0] {
      TAC_SEL_B9 = 2'b00,
      TAC_SEL_B3 = 2'b01,
      TAC_SEL_B5 = 2'b10,
      TAC_SEL_B7 = 2'b11
   } tac_sel_e;

   function automatic logic tac_tap(input logic [9:0] div, input logic [1:0] sel);
      logic t;
      t = div[9];
      case (sel)
         TAC_SEL_B9: t = div[9];
         TAC_SEL_B3: t = div[3];
         TAC_SEL_B5: t = div[5];
         TAC_SEL_B7: t = div[7];
      endcase
      return t;
   endfunction

endpackage

// File: rtl/gb_timer.sv
// Divider, TIMA/TMA/TAC and the tick falling-edge detector.
// ovf_o pulses in the same cycle TIMA reloads from TMA.
module gb_timer
   import hram_io_responder_pkg::*;
#(
   parameter int DIV_BITS = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_div_i,
   input  logic       wr_tima_i,
   input  logic       wr_tma_i,
   input  logic       wr_tac_i,
   input  logic [7:0] wdata_i,
   output logic [7:0] div_o,
   output logic [7:0] tima_o,
   output logic [7:0] tma_o,
   output logic [2:0] tac_o,
   output logic       ovf_o
);

   logic [DIV_BITS-1:0] div_q, div_d;
   logic [7:0]          tima_q, tima_d;
   logic [7:0]          tma_q, tma_d;
   logic [2:0]          tac_q, tac_d;
   logic                tick_q, tick_d;
   logic                inc;

   // The tick is evaluated on next state, so a DIV write or TAC change that
   // drops the tapped bit counts on the same edge as a natural fall.
   always_comb begin
      div_d  = wr_div_i ? '0 : div_q + DIV_BITS'(1);
      tac_d  = wr_tac_i ? wdata_i[2:0] : tac_q;
      tma_d  = wr_tma_i ? wdata_i : tma_q;
      tick_d = tac_d[2] & tac_tap(div_d[9:0], tac_d[1:0]);
      inc    = tick_q & ~tick_d;
      ovf_o  = inc & (tima_q == 8'hFF) & ~wr_tima_i;
      tima_d = tima_q;
      if (wr_tima_i)
         tima_d = wdata_i;
      else if (inc)
         tima_d = (tima_q == 8'hFF) ? tma_q : tima_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         div_q  <= '0;
         tima_q <= '0;
         tma_q  <= '0;
         tac_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         tima_q <= tima_d;
         tma_q  <= tma_d;
         tac_q  <= tac_d;
         tick_q <= tick_d;
      end
   end

   assign div_o  = div_q[DIV_BITS-1 -: 8];
   assign tima_o = tima_q;
   assign tma_o  = tma_q;
   assign tac_o  = tac_q;

endmodule

// File: rtl/hram_io_responder.sv
// High-page bus responder: HRAM, timer, IF/IE, zero-latency tristate read
// and the pending-interrupt vector.
module hram_io_responder
   import hram_io_responder_pkg::*;
#(
   parameter logic [15:0] HRAM_BASE  = 16'hFF80,
   parameter int          HRAM_DEPTH = 127,
   parameter int          DIV_BITS   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] address,
   inout  wire  [7:0]  databus,
   input  logic        RE,
   input  logic        WE,
   output logic        sel,
   input  logic [4:0]  irq_src,
   input  logic [4:0]  int_ack,
   output logic [4:0]  int_pending
);

   localparam int          AW       = $clog2(HRAM_DEPTH);
   localparam logic [16:0] HRAM_END = {1'b0, HRAM_BASE} + 17'(HRAM_DEPTH);

   logic          hit_hram, hit_reg, wr, drive;
   logic [AW-1:0] hram_idx;
   logic [7:0]    hram_q [HRAM_DEPTH];
   logic [7:0]    rdata;
   logic [4:0]    if_q, if_d, set_src;
   logic [7:0]    ie_q, ie_d;
   logic [7:0]    t_div, t_tima, t_tma;
   logic [2:0]    t_tac;
   logic          t_ovf;

   assign hit_hram = (address >= HRAM_BASE) && ({1'b0, address} < HRAM_END);
   assign hit_reg  = (address == ADDR_DIV) || (address == ADDR_TIMA) ||
                     (address == ADDR_TMA) || (address == ADDR_TAC)  ||
                     (address == ADDR_IF)  || (address == ADDR_IE);
   assign sel      = hit_hram | hit_reg;
   assign hram_idx = AW'(address - HRAM_BASE);

   // RE+WE together is a write; nothing happens while reset is held.
   assign wr    = rst & WE & sel;
   assign drive = rst & sel & RE & ~WE;

   gb_timer #(.DIV_BITS(DIV_BITS)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .wr_div_i  (wr & (address == ADDR_DIV)),
      .wr_tima_i (wr & (address == ADDR_TIMA)),
      .wr_tma_i  (wr & (address == ADDR_TMA)),
      .wr_tac_i  (wr & (address == ADDR_TAC)),
      .wdata_i   (databus),
      .div_o     (t_div),
      .tima_o    (t_tima),
      .tma_o     (t_tma),
      .tac_o     (t_tac),
      .ovf_o     (t_ovf)
   );

   always_ff @(posedge clk) begin
      if (wr && hit_hram)
         hram_q[hram_idx] <= databus;
   end

   // Set sources beat both the ack and a CPU write landing in the same cycle.
   always_comb begin
      set_src            = irq_src;
      set_src[INT_TIMER] = irq_src[INT_TIMER] | t_ovf;
      if_d = (((wr && address == ADDR_IF) ? databus[4:0] : if_q) & ~int_ack) | set_src;
      ie_d = (wr && address == ADDR_IE) ? databus : ie_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if_q <= '0;
         ie_q <= '0;
      end else begin
         if_q <= if_d;
         ie_q <= ie_d;
      end
   end

   always_comb begin
      rdata = 8'h00;
      if (hit_hram)
         rdata = hram_q[hram_idx];
      else begin
         case (address)
            ADDR_DIV:  rdata = t_div;
            ADDR_TIMA: rdata = t_tima;
            ADDR_TMA:  rdata = t_tma;
            ADDR_TAC:  rdata = {5'b11111, t_tac};
            ADDR_IF:   rdata = {3'b111, if_q};
            ADDR_IE:   rdata = ie_q;
            default:   rdata = 8'h00;
         endcase
      end
   end

   assign databus     = drive ? rdata : 8'bz;
   assign int_pending = ie_q[4:0] & if_q;

endmodule
